// File: rtl/hit_detector_pkg.sv
// ---------------------------------------------------------------------------
// hit_detector_pkg
// Shared game definitions used by the hit detector, and later by the throw
// controller and the draw logic.
//   result_t : outcome of a throw (none / hit / miss)
//   state_t  : hit detector FSM states
//   SCREEN_W / GROUND_Y : playfield limits in pixels
// ---------------------------------------------------------------------------
package hit_detector_pkg;

    localparam int POS_W          = 12;
    localparam int SCREEN_W       = 1024;
    localparam int GROUND_Y       = 700;
    localparam int PROJ_SIZE      = 16;
    localparam int TARGET_W       = 64;
    localparam int TARGET_H       = 64;
    localparam int TIMEOUT_CYCLES = 4_000_000;
    localparam int SCORE_W        = 8;

    typedef enum logic [1:0] {
        RES_NONE,
        RES_HIT,
        RES_MISS
    } result_t;

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        REPORT
    } state_t;

    // Zero-extend a 12-bit coordinate so sums with box sizes cannot wrap.
    function automatic logic [POS_W:0] widen(input logic [POS_W-1:0] v);
        return {1'b0, v};
    endfunction

endpackage

// File: rtl/hit_detector_box_overlap.sv
// ---------------------------------------------------------------------------
// box_overlap
// Purely combinational rectangle intersection test. Box A has size A_W x A_H
// with its top-left corner at (a_x, a_y); box B has size B_W x B_H at
// (b_x, b_y). All arithmetic is 13 bits wide so coordinates near 4095 do not
// wrap around.
// Ports:
//   a_x, a_y  in  12  top-left corner of box A
//   b_x, b_y  in  12  top-left corner of box B
//   overlap   out 1   boxes share at least one pixel
// ---------------------------------------------------------------------------
module box_overlap
    import hit_detector_pkg::*;
#(
    parameter int A_W = 16,
    parameter int A_H = 16,
    parameter int B_W = 64,
    parameter int B_H = 64
) (
    input  logic [11:0] a_x,
    input  logic [11:0] a_y,
    input  logic [11:0] b_x,
    input  logic [11:0] b_y,
    output logic        overlap
);

    logic [12:0] ax;
    logic [12:0] ay;
    logic [12:0] bx;
    logic [12:0] by;

    assign ax = widen(a_x);
    assign ay = widen(a_y);
    assign bx = widen(b_x);
    assign by = widen(b_y);

    // Strict inequalities: boxes that only touch along an edge do not overlap.
    assign overlap = (ax < bx + 13'(B_W)) &&
                     (ax + 13'(A_W) > bx) &&
                     (ay < by + 13'(B_H)) &&
                     (ay + 13'(A_H) > by);

endmodule

// File: rtl/hit_detector.sv
// ---------------------------------------------------------------------------
// hit_detector
// Receiving end of the projectile position stream. Arms on throw_start,
// follows x_pos/y_pos updates and decides HIT (projectile box overlaps the
// target box) or MISS (ground reached, screen left, or position stalled for
// TIMEOUT_CYCLES). Results are one-cycle pulses; a saturating score counts
// hits.
// Ports:
//   clk          in  1   system clock
//   rst_n        in  1   asynchronous active-low reset
//   throw_start  in  1   launch pulse, ignored while busy
//   x_pos/y_pos  in  12  projectile top-left corner
//   target_x/y   in  12  target top-left corner
//   clear_score  in  1   synchronous clear of hit_cnt (wins over increment)
//   busy         out 1   high in TRACK and REPORT
//   hit / miss   out 1   one-cycle result pulses
//   hit_cnt      out 8   saturating hit counter
// ---------------------------------------------------------------------------
module hit_detector #(
    parameter int SCREEN_W       = hit_detector_pkg::SCREEN_W,
    parameter int GROUND_Y       = hit_detector_pkg::GROUND_Y,
    parameter int PROJ_SIZE      = hit_detector_pkg::PROJ_SIZE,
    parameter int TARGET_W       = hit_detector_pkg::TARGET_W,
    parameter int TARGET_H       = hit_detector_pkg::TARGET_H,
    parameter int TIMEOUT_CYCLES = hit_detector_pkg::TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        throw_start,
    input  logic [11:0] x_pos,
    input  logic [11:0] y_pos,
    input  logic [11:0] target_x,
    input  logic [11:0] target_y,
    input  logic        clear_score,
    output logic        busy,
    output logic        hit,
    output logic        miss,
    output logic [7:0]  hit_cnt
);

    import hit_detector_pkg::*;

    localparam int TCW = $clog2(TIMEOUT_CYCLES);

    state_t        state;
    state_t        next_state;
    result_t       result;
    result_t       next_result;

    logic [11:0]   prev_x;
    logic [11:0]   prev_y;
    logic [11:0]   s1_x;
    logic [11:0]   s1_y;
    logic          s1_valid;
    logic          s2_ovl;
    logic          s2_gnd;
    logic          s2_off;
    logic [TCW-1:0] timeout_cnt;
    logic          change;
    logic          ovl_now;
    logic          timeout_hit;
    logic [7:0]    score;

    assign change      = (x_pos != prev_x) || (y_pos != prev_y);
    assign timeout_hit = (timeout_cnt == TCW'(TIMEOUT_CYCLES - 1));

    box_overlap #(
        .A_W (PROJ_SIZE),
        .A_H (PROJ_SIZE),
        .B_W (TARGET_W),
        .B_H (TARGET_H)
    ) u_overlap (
        .a_x     (s1_x),
        .a_y     (s1_y),
        .b_x     (target_x),
        .b_y     (target_y),
        .overlap (ovl_now)
    );

    // State and latched outcome register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            result <= RES_NONE;
        end else begin
            state  <= next_state;
            result <= next_result;
        end
    end

    // Next-state logic. A sample already in stage 2 is decided before the
    // timeout is considered, and overlap wins over ground/off-screen.
    always_comb begin
        next_state  = state;
        next_result = result;
        case (state)
            IDLE: begin
                next_result = RES_NONE;
                if (throw_start) begin
                    next_state = TRACK;
                end
            end
            TRACK: begin
                if (s2_ovl) begin
                    next_state  = REPORT;
                    next_result = RES_HIT;
                end else if (s2_gnd || s2_off) begin
                    next_state  = REPORT;
                    next_result = RES_MISS;
                end else if (timeout_hit) begin
                    next_state  = REPORT;
                    next_result = RES_MISS;
                end
            end
            REPORT: begin
                next_state = IDLE;
            end
            default: begin
                next_state  = IDLE;
                next_result = RES_NONE;
            end
        endcase
    end

    // Sample pipeline and stall timer. Outside TRACK the pipeline stays
    // flushed so stale flags can never leak into the next throw; the launch
    // position is captured into prev_x/prev_y so it is never evaluated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_x      <= '0;
            prev_y      <= '0;
            s1_x        <= '0;
            s1_y        <= '0;
            s1_valid    <= 1'b0;
            s2_ovl      <= 1'b0;
            s2_gnd      <= 1'b0;
            s2_off      <= 1'b0;
            timeout_cnt <= '0;
        end else if (state == TRACK) begin
            s1_valid <= change;
            if (change) begin
                prev_x      <= x_pos;
                prev_y      <= y_pos;
                s1_x        <= x_pos;
                s1_y        <= y_pos;
                timeout_cnt <= '0;
            end else begin
                timeout_cnt <= timeout_cnt + TCW'(1);
            end
            s2_ovl <= s1_valid && ovl_now;
            s2_gnd <= s1_valid && (widen(s1_y) >= 13'(GROUND_Y));
            s2_off <= s1_valid && (widen(s1_x) >= 13'(SCREEN_W));
        end else begin
            s1_valid    <= 1'b0;
            s2_ovl      <= 1'b0;
            s2_gnd      <= 1'b0;
            s2_off      <= 1'b0;
            timeout_cnt <= '0;
            if (state == IDLE && throw_start) begin
                prev_x <= x_pos;
                prev_y <= y_pos;
            end
        end
    end

    // Saturating score; a clear request beats a simultaneous hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score <= '0;
        end else if (clear_score) begin
            score <= '0;
        end else if (state == REPORT && result == RES_HIT && score != 8'hFF) begin
            score <= score + 8'd1;
        end
    end

    assign busy    = (state != IDLE);
    assign hit     = (state == REPORT) && (result == RES_HIT);
    assign miss    = (state == REPORT) && (result == RES_MISS);
    assign hit_cnt = score;

endmodule
